reg_native_arb: RTL and testbench

REG_NATIVE_ARB -- requirements
Module: reg_native_arb

---
 rtl/reg_native_arb_pkg.sv | 13 +
 rtl/reg_native_arb_rr.sv | 30 +++
 rtl/reg_native_arb.sv | 184 ++++++++++++++++++
 tb/tb_reg_native_arb.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_native_arb_pkg.sv
// Shared types and constants for the reg_native arbiter.
package reg_native_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK,
        ERR
    } state_t;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/reg_native_arb_rr.sv
// Combinational round-robin selector: the search starts one past the last
// granted requester and wraps, returning a one-hot grant.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant
);

    logic [IW:0]    shift;
    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] rot_full;
    logic [2*N-1:0] back_full;
    logic [N-1:0]   rotated;
    logic [N-1:0]   pick;

    // Rotate requests so the preferred requester sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        shift     = {1'b0, last_grant} + (IW + 1)'(1);
        req_dbl   = {req, req};
        rot_full  = req_dbl >> shift;
        rotated   = rot_full[N-1:0];
        pick      = rotated & (~rotated + N'(1));
        back_full = {{N{1'b0}}, pick} << shift;
        grant     = back_full[N-1:0] | back_full[2*N-1:N];
    end

endmodule

// File: rtl/reg_native_arb.sv
// Multi-requester arbiter onto a single reg_native downstream port with one
// transaction outstanding, timeout error completion and illegal-op rejection.
module reg_native_arb
    import reg_native_arb_pkg::*;
#(
    parameter int                    NUM_MST     = 3,
    parameter int                    ADDR_WIDTH  = 64,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    TIMEOUT_CYC = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA    = DATA_WIDTH'(DEFAULT_ERR_DATA)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MST-1:0]            m_req_vld,
    output logic [NUM_MST-1:0]            m_req_rdy,
    input  logic [NUM_MST-1:0]            m_wr_en,
    input  logic [NUM_MST-1:0]            m_rd_en,
    input  logic [NUM_MST*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MST*DATA_WIDTH-1:0] m_wr_data,
    output logic [NUM_MST-1:0]            m_ack_vld,
    input  logic [NUM_MST-1:0]            m_ack_rdy,
    output logic [DATA_WIDTH-1:0]         m_rd_data,
    output logic                          s_req_vld,
    output logic                          s_wr_en,
    output logic                          s_rd_en,
    input  logic                          s_req_rdy,
    output logic [ADDR_WIDTH-1:0]         s_addr,
    output logic [DATA_WIDTH-1:0]         s_wr_data,
    input  logic                          s_ack_vld,
    output logic                          s_ack_rdy,
    input  logic [DATA_WIDTH-1:0]         s_rd_data,
    output logic                          timeout_err
);

    localparam int IW = $clog2(NUM_MST);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [IW-1:0]           last_grant;
    logic [IW-1:0]           g_idx;
    logic [NUM_MST-1:0]      g_oh;
    logic                    op_wr;
    logic                    op_rd;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic [CW-1:0]           cnt;

    logic [NUM_MST-1:0]      arb_grant;
    logic [IW-1:0]           arb_idx;
    logic                    sel_wr;
    logic                    sel_rd;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic                    grant_fire;
    logic                    ack_rdy_g;
    logic                    cnt_expired;
    logic                    timeout_hit;
    logic                    done;

    rr_arbiter #(
        .N  (NUM_MST),
        .IW (IW)
    ) u_rr (
        .req        (m_req_vld),
        .last_grant (last_grant),
        .grant      (arb_grant)
    );

    assign grant_fire  = (state == IDLE) && (|m_req_vld) && !rst;
    assign ack_rdy_g   = |(m_ack_rdy & g_oh);
    assign cnt_expired = (cnt >= CW'(TIMEOUT_CYC - 1));

    // Pick out the winning requester's index, op and payload from the packed buses.
    always_comb begin
        arb_idx   = '0;
        sel_wr    = 1'b0;
        sel_rd    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (arb_grant[i]) begin
                arb_idx   = IW'(i);
                sel_wr    = m_wr_en[i];
                sel_rd    = m_rd_en[i];
                sel_addr  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = m_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // State, grant bookkeeping, latched request fields and the timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= IW'(NUM_MST - 1);
            g_idx       <= '0;
            g_oh        <= '0;
            op_wr       <= 1'b0;
            op_rd       <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            timeout_err <= timeout_hit;
            if (grant_fire) begin
                g_idx     <= arb_idx;
                g_oh      <= arb_grant;
                op_wr     <= sel_wr;
                op_rd     <= sel_rd;
                lat_addr  <= sel_addr;
                lat_wdata <= sel_wdata;
                cnt       <= '0;
            end else if (state == REQ || state == ACK) begin
                cnt <= cnt + CW'(1);
            end
            if (done) begin
                last_grant <= g_idx;
            end
        end
    end

    // Next-state and all port outputs; anything not driven by the current state stays zero.
    always_comb begin
        state_nxt   = state;
        m_req_rdy   = '0;
        m_ack_vld   = '0;
        m_rd_data   = '0;
        s_req_vld   = 1'b0;
        s_wr_en     = 1'b0;
        s_rd_en     = 1'b0;
        s_addr      = '0;
        s_wr_data   = '0;
        s_ack_rdy   = 1'b0;
        timeout_hit = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (grant_fire) begin
                    m_req_rdy = arb_grant;
                    state_nxt = (sel_wr ^ sel_rd) ? REQ : ERR;
                end
            end
            REQ: begin
                s_req_vld = !cnt_expired;
                s_wr_en   = op_wr;
                s_rd_en   = op_rd;
                s_addr    = lat_addr;
                s_wr_data = lat_wdata;
                if (cnt_expired) begin
                    state_nxt   = ERR;
                    timeout_hit = 1'b1;
                end else if (s_req_rdy) begin
                    state_nxt = ACK;
                end
            end
            ACK: begin
                m_ack_vld = g_oh & {NUM_MST{s_ack_vld}};
                m_rd_data = s_rd_data;
                s_ack_rdy = ack_rdy_g;
                if (s_ack_vld && ack_rdy_g) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end else if (cnt_expired) begin
                    s_ack_rdy   = 1'b0;
                    state_nxt   = ERR;
                    timeout_hit = 1'b1;
                end
            end
            ERR: begin
                m_ack_vld = g_oh;
                m_rd_data = ERR_DATA;
                if (ack_rdy_g) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg_native_arb.sv
// Directed testbench for reg_native_arb with hand-computed expected values.
module tb_reg_native_arb;

    localparam int NM = 3;
    localparam int AW = 64;
    localparam int DW = 32;

    logic             clk;
    logic             rst;
    logic [NM-1:0]    m_req_vld;
    logic [NM-1:0]    m_req_rdy;
    logic [NM-1:0]    m_wr_en;
    logic [NM-1:0]    m_rd_en;
    logic [NM*AW-1:0] m_addr;
    logic [NM*DW-1:0] m_wr_data;
    logic [NM-1:0]    m_ack_vld;
    logic [NM-1:0]    m_ack_rdy;
    logic [DW-1:0]    m_rd_data;
    logic             s_req_vld;
    logic             s_wr_en;
    logic             s_rd_en;
    logic             s_req_rdy;
    logic [AW-1:0]    s_addr;
    logic [DW-1:0]    s_wr_data;
    logic             s_ack_vld;
    logic             s_ack_rdy;
    logic [DW-1:0]    s_rd_data;
    logic             timeout_err;

    int compared   = 0;
    int mismatched = 0;

    reg_native_arb #(
        .NUM_MST     (NM),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .TIMEOUT_CYC (8),
        .ERR_DATA    (32'hDEAD_BEEF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m_req_vld   (m_req_vld),
        .m_req_rdy   (m_req_rdy),
        .m_wr_en     (m_wr_en),
        .m_rd_en     (m_rd_en),
        .m_addr      (m_addr),
        .m_wr_data   (m_wr_data),
        .m_ack_vld   (m_ack_vld),
        .m_ack_rdy   (m_ack_rdy),
        .m_rd_data   (m_rd_data),
        .s_req_vld   (s_req_vld),
        .s_wr_en     (s_wr_en),
        .s_rd_en     (s_rd_en),
        .s_req_rdy   (s_req_rdy),
        .s_addr      (s_addr),
        .s_wr_data   (s_wr_data),
        .s_ack_vld   (s_ack_vld),
        .s_ack_rdy   (s_ack_rdy),
        .s_rd_data   (s_rd_data),
        .timeout_err (timeout_err)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] idx, input logic vld, input logic wr, input logic rd,
                                 input logic [63:0] addr, input logic [31:0] data);
        m_req_vld[idx]          = vld;
        m_wr_en[idx]            = wr;
        m_rd_en[idx]            = rd;
        m_addr[idx*AW +: AW]    = addr;
        m_wr_data[idx*DW +: DW] = data;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_req_rdy"}, 64'(m_req_rdy), 64'h0);
        checkOutput({tag, "_ack_vld"}, 64'(m_ack_vld), 64'h0);
        checkOutput({tag, "_rd_data"}, 64'(m_rd_data), 64'h0);
        checkOutput({tag, "_s_req_vld"}, 64'(s_req_vld), 64'h0);
        checkOutput({tag, "_s_ack_rdy"}, 64'(s_ack_rdy), 64'h0);
        checkOutput({tag, "_tmo"}, 64'(timeout_err), 64'h0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    // Directed sequence: reset, single write, contention, read with backpressure,
    // reset in ACK, timeout and illegal op.
    initial begin
        rst       = 1'b1;
        m_req_vld = '0;
        m_wr_en   = '0;
        m_rd_en   = '0;
        m_addr    = '0;
        m_wr_data = '0;
        m_ack_rdy = '0;
        s_req_rdy = 1'b1;
        s_ack_vld = 1'b0;
        s_rd_data = '0;

        doReset();
        checkIdleOutputs("reset");
        checkOutput("reset_s_addr", s_addr, 64'h0);

        // Single write from m0
        step();
        applyStimulus(2'd0, 1'b1, 1'b1, 1'b0, 64'h200, 32'hFFFF_FFFF);
        #1;
        checkOutput("wr_grant", 64'(m_req_rdy), 64'b001);
        step();
        applyStimulus(2'd0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
        #1;
        checkOutput("wr_s_req_vld", 64'(s_req_vld), 64'h1);
        checkOutput("wr_s_addr", s_addr, 64'h200);
        checkOutput("wr_s_wr_data", 64'(s_wr_data), 64'hFFFF_FFFF);
        checkOutput("wr_s_wr_en", 64'(s_wr_en), 64'h1);
        checkOutput("wr_s_rd_en", 64'(s_rd_en), 64'h0);
        checkOutput("wr_no_rdy", 64'(m_req_rdy), 64'h0);
        step();
        #1;
        checkOutput("wr_req_drop", 64'(s_req_vld), 64'h0);
        checkOutput("wr_ack_wait", 64'(m_ack_vld), 64'h0);
        step();
        s_ack_vld = 1'b1;
        m_ack_rdy = 3'b001;
        #1;
        checkOutput("wr_ack_vld", 64'(m_ack_vld), 64'b001);
        checkOutput("wr_s_ack_rdy", 64'(s_ack_rdy), 64'h1);
        step();
        s_ack_vld = 1'b0;
        m_ack_rdy = '0;
        #1;
        checkOutput("wr_ack_done", 64'(m_ack_vld), 64'h0);

        // Contention: all three held for two full rounds after reset
        doReset();
        applyStimulus(2'd0, 1'b1, 1'b1, 1'b0, 64'h10, 32'h1);
        applyStimulus(2'd1, 1'b1, 1'b1, 1'b0, 64'h20, 32'h2);
        applyStimulus(2'd2, 1'b1, 1'b1, 1'b0, 64'h30, 32'h3);
        s_ack_vld = 1'b1;
        m_ack_rdy = 3'b111;
        #1;
        for (int t = 0; t < 6; t++) begin
            logic [2:0] exp_oh;
            exp_oh = 3'b001 << (t % 3);
            checkOutput($sformatf("cont_grant_%0d", t), 64'(m_req_rdy), 64'(exp_oh));
            step();
            #1;
            checkOutput($sformatf("cont_addr_%0d", t), s_addr, 64'(16 * ((t % 3) + 1)));
            step();
            #1;
            checkOutput($sformatf("cont_ack_%0d", t), 64'(m_ack_vld), 64'(exp_oh));
            step();
            #1;
        end
        m_req_vld = '0;
        s_ack_vld = 1'b0;
        m_ack_rdy = '0;
        #1;
        checkOutput("cont_idle", 64'(m_req_rdy), 64'h0);

        // Read from m1 with completion backpressure
        step();
        applyStimulus(2'd1, 1'b1, 1'b0, 1'b1, 64'h300, 32'h0);
        #1;
        checkOutput("rd_grant", 64'(m_req_rdy), 64'b010);
        step();
        applyStimulus(2'd1, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
        #1;
        checkOutput("rd_s_rd_en", 64'(s_rd_en), 64'h1);
        checkOutput("rd_s_addr", s_addr, 64'h300);
        for (int k = 0; k < 3; k++) begin
            step();
            s_ack_vld = 1'b1;
            s_rd_data = 32'h1234_5678;
            #1;
            checkOutput($sformatf("rd_hold_vld_%0d", k), 64'(m_ack_vld), 64'b010);
            checkOutput($sformatf("rd_hold_data_%0d", k), 64'(m_rd_data), 64'h1234_5678);
            checkOutput($sformatf("rd_hold_s_rdy_%0d", k), 64'(s_ack_rdy), 64'h0);
        end
        step();
        m_ack_rdy = 3'b010;
        #1;
        checkOutput("rd_s_ack_rdy", 64'(s_ack_rdy), 64'h1);
        checkOutput("rd_data_final", 64'(m_rd_data), 64'h1234_5678);
        step();
        s_ack_vld = 1'b0;
        m_ack_rdy = '0;
        #1;
        checkOutput("rd_done_vld", 64'(m_ack_vld), 64'h0);
        checkOutput("rd_done_data", 64'(m_rd_data), 64'h0);

        // Reset while in ACK; last_grant was 1, so without reset m2 would win next
        step();
        applyStimulus(2'd2, 1'b1, 1'b0, 1'b1, 64'h400, 32'h0);
        #1;
        checkOutput("rsta_grant", 64'(m_req_rdy), 64'b100);
        step();
        applyStimulus(2'd2, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
        #1;
        checkOutput("rsta_s_req", 64'(s_req_vld), 64'h1);
        step();
        s_ack_vld = 1'b1;
        s_rd_data = 32'hCAFE_0001;
        #1;
        checkOutput("rsta_ack_vld", 64'(m_ack_vld), 64'b100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checkIdleOutputs("rsta_after");
        step();
        s_ack_vld = 1'b0;
        applyStimulus(2'd0, 1'b1, 1'b1, 1'b0, 64'h500, 32'h55);
        applyStimulus(2'd2, 1'b1, 1'b1, 1'b0, 64'h600, 32'h66);
        #1;
        checkOutput("rsta_first_grant", 64'(m_req_rdy), 64'b001);
        step();
        applyStimulus(2'd0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
        applyStimulus(2'd2, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
        #1;
        checkOutput("rsta_s_addr", s_addr, 64'h500);
        step();
        s_ack_vld = 1'b1;
        m_ack_rdy = 3'b001;
        #1;
        checkOutput("rsta_m0_ack", 64'(m_ack_vld), 64'b001);
        step();
        s_ack_vld = 1'b0;
        m_ack_rdy = '0;

        // Timeout: downstream accepts but never acknowledges
        applyStimulus(2'd0, 1'b1, 1'b1, 1'b0, 64'h700, 32'h77);
        #1;
        checkOutput("tmo_grant", 64'(m_req_rdy), 64'b001);
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 1) begin
                applyStimulus(2'd0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
            end
            #1;
            checkOutput($sformatf("tmo_wait_err_%0d", k), 64'(timeout_err), 64'h0);
            checkOutput($sformatf("tmo_wait_ack_%0d", k), 64'(m_ack_vld), 64'h0);
        end
        step();
        #1;
        checkOutput("tmo_pulse", 64'(timeout_err), 64'h1);
        checkOutput("tmo_ack_vld", 64'(m_ack_vld), 64'b001);
        checkOutput("tmo_rd_data", 64'(m_rd_data), 64'hDEAD_BEEF);
        checkOutput("tmo_s_ack_rdy", 64'(s_ack_rdy), 64'h0);
        checkOutput("tmo_s_req_vld", 64'(s_req_vld), 64'h0);
        step();
        #1;
        checkOutput("tmo_pulse_end", 64'(timeout_err), 64'h0);
        checkOutput("tmo_ack_held", 64'(m_ack_vld), 64'b001);
        m_ack_rdy = 3'b001;
        step();
        m_ack_rdy = '0;
        #1;
        checkOutput("tmo_done", 64'(m_ack_vld), 64'h0);

        // Illegal op from m2: both wr_en and rd_en set
        step();
        applyStimulus(2'd2, 1'b1, 1'b1, 1'b1, 64'h800, 32'h88);
        #1;
        checkOutput("ill_grant", 64'(m_req_rdy), 64'b100);
        step();
        applyStimulus(2'd2, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
        #1;
        checkOutput("ill_no_fwd", 64'(s_req_vld), 64'h0);
        checkOutput("ill_ack_vld", 64'(m_ack_vld), 64'b100);
        checkOutput("ill_rd_data", 64'(m_rd_data), 64'hDEAD_BEEF);
        checkOutput("ill_no_tmo", 64'(timeout_err), 64'h0);
        m_ack_rdy = 3'b100;
        step();
        m_ack_rdy = '0;
        #1;
        checkOutput("ill_done", 64'(m_ack_vld), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
